// File: rtl/pio_clkdiv_pkg.sv
// Shared widths, reset divisor and per-lane state layout for the PIO clock-enable scheduler.
package pio_clkdiv_pkg;
   localparam int INT_W  = 16;
   localparam int FRAC_W = 8;
   localparam int CNT_W  = INT_W + 1;

   localparam logic [INT_W-1:0]  DIV_INT_RST  = INT_W'(1);
   localparam logic [FRAC_W-1:0] DIV_FRAC_RST = '0;

   typedef struct packed {
      logic [CNT_W-1:0]  cnt;
      logic [FRAC_W-1:0] acc;
      logic [INT_W-1:0]  div_int;
      logic [FRAC_W-1:0] div_frac;
   } lane_state_t;
endpackage

// File: rtl/pio_clkdiv_lane.sv
// One fractional divider lane: stored divisor, down-counter, phase accumulator and tick flop.
module pio_clkdiv_lane
   import pio_clkdiv_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              wr,
   input  logic [INT_W-1:0]  wr_int,
   input  logic [FRAC_W-1:0] wr_frac,
   input  logic              enable,
   input  logic              restart,
   output logic              tick,
   output logic [INT_W-1:0]  div_int,
   output logic [FRAC_W-1:0] div_frac
);
   lane_state_t      st;
   logic [CNT_W-1:0] eff;
   logic [CNT_W-1:0] reload;
   logic [FRAC_W:0]  acc_sum;

   // A zero integer divisor stands for 2^INT_W, hence the extra counter bit.
   always_comb begin
      eff     = (st.div_int == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, st.div_int};
      acc_sum = {1'b0, st.acc} + {1'b0, st.div_frac};
      reload  = eff - CNT_W'(1) + {{INT_W{1'b0}}, acc_sum[FRAC_W]};
   end

   // NOTE: every state bit here, divisor registers included, uses <= so all
   //       lanes sample the same pre-edge values; the reset is synchronous.
   always_ff @(posedge clock) begin
      if (reset) begin
         st   <= '{cnt: '0, acc: '0, div_int: DIV_INT_RST, div_frac: DIV_FRAC_RST};
         tick <= 1'b0;
      end else begin
         if (wr) begin
            st.div_int  <= wr_int;
            st.div_frac <= wr_frac;
         end
         if (restart) begin
            st.cnt <= '0;
            st.acc <= '0;
            tick   <= 1'b0;
         end else if (!enable) begin
            tick <= 1'b0;
         end else if (st.cnt == '0) begin
            tick   <= 1'b1;
            st.acc <= acc_sum[FRAC_W-1:0];
            st.cnt <= reload;
         end else begin
            st.cnt <= st.cnt - CNT_W'(1);
            tick   <= 1'b0;
         end
      end
   end

   assign div_int  = st.div_int;
   assign div_frac = st.div_frac;
endmodule

// File: rtl/pio_clkdiv_ctrl.sv
// Per-state-machine clock-enable scheduler: config decode, readback mux and NUM_SM divider lanes.
module pio_clkdiv_ctrl #(
   parameter int NUM_SM = 4,
   parameter int INT_W  = pio_clkdiv_pkg::INT_W,
   parameter int FRAC_W = pio_clkdiv_pkg::FRAC_W,
   localparam int SM_W  = (NUM_SM > 1) ? $clog2(NUM_SM) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cfg_wr,
   input  logic [SM_W-1:0]   cfg_sm,
   input  logic [INT_W-1:0]  cfg_int,
   input  logic [FRAC_W-1:0] cfg_frac,
   input  logic [NUM_SM-1:0] sm_enable,
   input  logic [NUM_SM-1:0] clkdiv_restart,
   output logic [NUM_SM-1:0] tick,
   output logic [INT_W-1:0]  rd_int,
   output logic [FRAC_W-1:0] rd_frac
);
   logic [INT_W-1:0]  lane_int  [NUM_SM];
   logic [FRAC_W-1:0] lane_frac [NUM_SM];

   for (genvar g = 0; g < NUM_SM; g++) begin : g_lane
      pio_clkdiv_lane u_lane (
         .clock    (clock),
         .reset    (reset),
         .wr       (cfg_wr && (cfg_sm == SM_W'(g))),
         .wr_int   (cfg_int),
         .wr_frac  (cfg_frac),
         .enable   (sm_enable[g]),
         .restart  (clkdiv_restart[g]),
         .tick     (tick[g]),
         .div_int  (lane_int[g]),
         .div_frac (lane_frac[g])
      );
   end

   // Selects that match no lane (non-power-of-2 NUM_SM) read back as zero.
   always_comb begin
      rd_int  = '0;
      rd_frac = '0;
      for (int i = 0; i < NUM_SM; i++) begin
         if (cfg_sm == SM_W'(i)) begin
            rd_int  = lane_int[i];
            rd_frac = lane_frac[i];
         end
      end
   end
endmodule

// File: tb/tb_pio_clkdiv_ctrl.sv
// Self-checking bench for pio_clkdiv_ctrl: per-cycle model comparison plus literal interval checks.
module tb_pio_clkdiv_ctrl;
   localparam int NUM_SM = 4;
   localparam int INT_W  = 16;
   localparam int FRAC_W = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic              cfg_wr;
   logic [1:0]        cfg_sm;
   logic [INT_W-1:0]  cfg_int;
   logic [FRAC_W-1:0] cfg_frac;
   logic [NUM_SM-1:0] sm_enable;
   logic [NUM_SM-1:0] clkdiv_restart;
   logic [NUM_SM-1:0] tick;
   logic [INT_W-1:0]  rd_int;
   logic [FRAC_W-1:0] rd_frac;

   pio_clkdiv_ctrl #(.NUM_SM(NUM_SM), .INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
      .clock          (clock),
      .reset          (reset),
      .cfg_wr         (cfg_wr),
      .cfg_sm         (cfg_sm),
      .cfg_int        (cfg_int),
      .cfg_frac       (cfg_frac),
      .sm_enable      (sm_enable),
      .clkdiv_restart (clkdiv_restart),
      .tick           (tick),
      .rd_int         (rd_int),
      .rd_frac        (rd_frac)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Model: enabled edges left until the next tick, plus the fractional phase.
   int m_int  [NUM_SM];
   int m_frac [NUM_SM];
   int m_acc  [NUM_SM];
   int m_togo [NUM_SM];
   logic [NUM_SM-1:0] m_tick;

   // Observed tick statistics, taken from the DUT outputs.
   int first  [NUM_SM];
   int last   [NUM_SM];
   int gap    [NUM_SM];
   int nticks [NUM_SM];

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic clear_stats();
      for (int i = 0; i < NUM_SM; i++) begin
         first[i] = -1; last[i] = 0; gap[i] = 0; nticks[i] = 0;
      end
   endtask

   task automatic model_edge();
      int eff;
      int sum;
      for (int i = 0; i < NUM_SM; i++) begin
         if (reset) begin
            m_int[i] = 1; m_frac[i] = 0; m_acc[i] = 0; m_togo[i] = 1; m_tick[i] = 1'b0;
         end else begin
            if (clkdiv_restart[i]) begin
               m_togo[i] = 1; m_acc[i] = 0; m_tick[i] = 1'b0;
            end else if (!sm_enable[i]) begin
               m_tick[i] = 1'b0;
            end else if (m_togo[i] == 1) begin
               eff       = (m_int[i] == 0) ? (1 << INT_W) : m_int[i];
               sum       = m_acc[i] + m_frac[i];
               m_togo[i] = eff + sum / (1 << FRAC_W);
               m_acc[i]  = sum % (1 << FRAC_W);
               m_tick[i] = 1'b1;
            end else begin
               m_togo[i] = m_togo[i] - 1;
               m_tick[i] = 1'b0;
            end
            if (cfg_wr && (int'(cfg_sm) == i)) begin
               m_int[i]  = int'(cfg_int);
               m_frac[i] = int'(cfg_frac);
            end
         end
      end
   endtask

   // One clock: update the model at the edge, compare 1 time unit later, then drop pulses.
   task automatic step();
      @(posedge clock);
      model_edge();
      cyc++;
      #1;
      tests++;
      if (tick !== m_tick || rd_int !== INT_W'(m_int[cfg_sm]) || rd_frac !== FRAC_W'(m_frac[cfg_sm])) begin
         fails++;
         $display("FAIL cycle %0d: tick=%b rd=%0d/%0d, expected tick=%b rd=%0d/%0d",
                  cyc, tick, rd_int, rd_frac, m_tick, m_int[cfg_sm], m_frac[cfg_sm]);
      end
      for (int i = 0; i < NUM_SM; i++) begin
         if (tick[i] === 1'b1) begin
            if (first[i] < 0) first[i] = cyc;
            gap[i] = cyc - last[i];
            last[i] = cyc;
            nticks[i]++;
         end
      end
      cfg_wr         = 1'b0;
      clkdiv_restart = '0;
   endtask

   task automatic wait_tick(input int lane, input int max_cyc, input string name);
      int n = 0;
      do begin
         step();
         n++;
      end while (tick[lane] !== 1'b1 && n < max_cyc);
      if (tick[lane] !== 1'b1) check({name, " timeout"}, 0, 1);
   endtask

   task automatic write_cfg(input int sm, input int iv, input int fv);
      cfg_wr   = 1'b1;
      cfg_sm   = 2'(sm);
      cfg_int  = INT_W'(iv);
      cfg_frac = FRAC_W'(fv);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int t;
      int diff;
      reset = 1'b1; cfg_wr = 1'b0; cfg_sm = '0; cfg_int = '0; cfg_frac = '0;
      sm_enable = '0; clkdiv_restart = '0;
      for (int i = 0; i < NUM_SM; i++) begin
         m_int[i] = 1; m_frac[i] = 0; m_acc[i] = 0; m_togo[i] = 1;
      end
      m_tick = '0;
      clear_stats();
      repeat (3) step();

      // Reset defaults: lane 0 ticks on every enabled edge.
      reset = 1'b0;
      sm_enable = 4'b0001;
      clear_stats();
      repeat (6) step();
      check("default lane0 ticks", nticks[0], 6);
      check("default other lanes", nticks[1] + nticks[2] + nticks[3], 0);
      check("default rd_int", int'(rd_int), 1);
      check("default rd_frac", int'(rd_frac), 0);

      // Integer divide by 3 on lane 1.
      write_cfg(1, 3, 0);
      clkdiv_restart = 4'b0010;
      sm_enable = 4'b0011;
      step();
      r = cyc;
      clear_stats();
      repeat (10) step();
      check("div3 first tick delay", first[1] - r, 1);
      check("div3 period", gap[1], 3);
      check("div3 tick count", nticks[1], 4);
      check("div3 readback", int'(rd_int), 3);

      // Fractional 2.5 on lane 2: 200 intervals over 500 cycles.
      write_cfg(2, 2, 8'h80);
      clkdiv_restart = 4'b0100;
      sm_enable = 4'b0111;
      step();
      clear_stats();
      for (int k = 0; k < 1000 && nticks[2] < 201; k++) step();
      check("frac tick count", nticks[2], 201);
      check("frac 200-interval span", last[2] - first[2], 500);

      // Synchronised restart of lanes 0 and 1 after enabling them at different times.
      sm_enable = 4'b0000;
      write_cfg(0, 4, 0);
      step();
      write_cfg(1, 4, 0);
      step();
      sm_enable = 4'b0001;
      repeat (3) step();
      sm_enable = 4'b0011;
      repeat (2) step();
      clkdiv_restart = 4'b0011;
      step();
      clear_stats();
      diff = 0;
      repeat (20) begin
         step();
         if (tick[0] !== tick[1]) diff++;
      end
      check("sync lane mismatch cycles", diff, 0);
      check("sync lane0 tick count", nticks[0], 5);

      // Disable for 10 cycles mid-period; write and restart together select divisor 5.
      sm_enable = 4'b0010;
      write_cfg(1, 5, 0);
      clkdiv_restart = 4'b0010;
      step();
      wait_tick(1, 10, "div5 first tick");
      t = cyc;
      repeat (2) step();
      sm_enable = 4'b0000;
      repeat (10) step();
      sm_enable = 4'b0010;
      wait_tick(1, 20, "div5 after disable");
      check("disable stretches interval", cyc - t, 15);

      // Divisor write mid-period: current interval stays 5, later ones are 7.
      t = cyc;
      repeat (2) step();
      write_cfg(1, 7, 0);
      step();
      wait_tick(1, 20, "mid-write tick 1");
      check("mid-write current interval", cyc - t, 5);
      t = cyc;
      wait_tick(1, 20, "mid-write tick 2");
      check("mid-write next interval", cyc - t, 7);
      t = cyc;
      wait_tick(1, 20, "mid-write tick 3");
      check("mid-write later interval", cyc - t, 7);

      // Wrap: integer 0 means 65536; with an accumulated carry the interval is 65537.
      sm_enable = 4'b1000;
      write_cfg(3, 2, 8'hFF);
      clkdiv_restart = 4'b1000;
      step();
      wait_tick(3, 5, "wrap prefill tick");
      write_cfg(3, 0, 8'hFF);
      step();
      wait_tick(3, 5, "wrap reload tick");
      t = cyc;
      check("wrap readback int", int'(rd_int), 0);
      wait_tick(3, 70000, "wrap long tick");
      check("wrap max interval", cyc - t, 65537);

      // Reset mid-period overrides everything.
      sm_enable = 4'b1111;
      repeat (7) step();
      reset = 1'b1;
      step();
      check("reset kills tick", int'(tick), 0);
      reset = 1'b0;
      step();
      check("post-reset rd_int", int'(rd_int), 1);
      check("post-reset rd_frac", int'(rd_frac), 0);
      repeat (4) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pio_clkdiv_ctrl.md
# pio_clkdiv_ctrl

Per-state-machine clock-enable scheduler for the PIO block. Holds a 16.8 fixed-point divisor for each state machine and emits one-cycle `tick` enables at the programmed average rate. Supports per-SM enable/disable and a synchronised divider restart so that several state machines can be phase-aligned. Sits between the PIO control/config register file and the state-machine cores, which advance only on cycles where their `tick` bit is high.

## Interface

Parameters:
- `NUM_SM`, 4, number of state machines / divider lanes
- `INT_W`, 16, integer divisor width
- `FRAC_W`, 8, fractional divisor width

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `cfg_wr`  in  1  divisor write strobe, one cycle
- `cfg_sm`  in  $clog2(NUM_SM)  target lane for write and readback
- `cfg_int`  in  INT_W  integer divisor; 0 means 2^INT_W
- `cfg_frac`  in  FRAC_W  fractional divisor, units of 2^-FRAC_W
- `sm_enable`  in  NUM_SM  level enable per lane
- `clkdiv_restart`  in  NUM_SM  one-cycle pulse per lane, resets divider phase
- `tick`  out  NUM_SM  registered one-cycle clock-enable per lane
- `rd_int`  out  INT_W  stored integer divisor of lane `cfg_sm` (combinational)
- `rd_frac`  out  FRAC_W  stored fractional divisor of lane `cfg_sm` (combinational)

## Operation

- Per-lane state: `div_int`, `div_frac`, down-counter `cnt` (INT_W+1 bits), fractional accumulator `acc` (FRAC_W bits).
- Effective integer `eff = (div_int == 0) ? 2^INT_W : div_int`.
- Each cycle, lane i, priority order:
  - `clkdiv_restart[i]`: `cnt <= 0`, `acc <= 0`, `tick[i] <= 0`.
  - else `!sm_enable[i]`: `cnt`, `acc` hold; `tick[i] <= 0`.
  - else `cnt == 0`: `tick[i] <= 1`; `{carry, acc} <= acc + div_frac`; `cnt <= eff - 1 + carry`.
  - else: `cnt <= cnt - 1`; `tick[i] <= 0`.
- Resulting tick interval is `eff` or `eff+1`, with average `eff + div_frac/2^FRAC_W`. The first interval after restart uses carry from `acc = 0`.
- Config write: on `cfg_wr`, lane `cfg_sm` loads `cfg_int`/`cfg_frac`. The new value applies at that lane's next reload (`cnt == 0`); the current count is not disturbed.
  - A write and a restart to the same lane in the same cycle both apply, so the new divisor governs the first post-restart interval.
  - An out-of-range `cfg_sm` write (non-power-of-2 `NUM_SM`) is ignored; readback returns 0.
- Disable freezes phase; re-enable resumes the remaining count. Total enabled cycles between ticks are unchanged.
- Lanes are fully independent except for shared config decode.

## Timing

- Reset values: `tick = 0`, `div_int = 1`, `div_frac = 0`, `cnt = 0`, `acc = 0` for every lane. Defaults give a tick every enabled cycle.
- `tick` is registered. Enable sampled high at edge N with `cnt == 0` gives `tick` high in cycle N+1.
- Restart sampled at edge N gives `tick = 0` in N+1. If enabled, the first tick is in N+2.
  - Lanes restarted in the same cycle with equal divisors tick coincidentally thereafter.
- Config write at edge N is visible on `rd_*` in N+1.
- Maximum interval is 2^INT_W + 1 cycles; `cnt` width must hold 2^INT_W without overflow.
- `reset` overrides all inputs, including mid-period; no tick is emitted in the cycle after reset is sampled.

## Structure

- Package `pio_clkdiv_pkg`: `INT_W`, `FRAC_W` defaults, reset divisor constants (`DIV_INT_RST = 1`, `DIV_FRAC_RST = 0`), lane state struct (`cnt`, `acc`, `div_int`, `div_frac`).
- Sub-module `pio_clkdiv_lane`: one divider lane (config regs, counter, accumulator, tick flop), generated `NUM_SM` times.
- The top level holds `cfg_sm` decode and the readback mux.

## Test plan

- Reset defaults: release reset, `sm_enable = 4'b0001` → `tick[0]` high every cycle from the second cycle; `tick[3:1] = 0`; `rd_int = 1`, `rd_frac = 0`.
- Integer divide: lane 1 `cfg_int = 3`, `cfg_frac = 0`, restart, enable → `tick[1]` one cycle wide, period exactly 3, first tick 2 cycles after restart.
- Fractional: lane 2 `cfg_int = 2`, `cfg_frac = 0x80` → intervals 2,3,2,3…; 200 ticks span exactly 500 cycles.
- Wrap: `cfg_int = 0`, `cfg_frac = 0` → interval 65536. Then `cfg_int = 0`, `cfg_frac = 0xFF` → intervals of 65536 and 65537, and the counter never overflows.
- Sync restart: lanes 0 and 1 `cfg_int = 4`, enabled at different cycles, then `clkdiv_restart = 4'b0011` → identical tick cycles thereafter.
- Disable/config mid-period:
  - `cfg_int = 5`; drop enable 2 cycles after a tick for 10 cycles → next tick after 5 enabled cycles total.
  - Write `cfg_int = 7` mid-period → current interval stays 5, following intervals are 7.
